alu_seq: RTL

Parametrised, handshaked successor to the single-cycle datapath ALU. Executes the existing add/and/or/sub operations in one registered cycle and adds iterative unsigned multiply, divide and remainder (one bit per cycle). Sits between the operand mux (ReadData1 / muxed ReadData2-or-immediate) and writeback in the multi-cycle core. Result and zero flag are registered and held until consumed.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_iter_muldiv.sv | 98 +++++++++
 rtl/alu_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op-classification helpers for alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_DONE
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_divide(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial unsigned multiplier (LSB-first shift-add) and restoring divider (MSB-first).
// Results are exposed from the next-state values so the caller can register them on the final step.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // acc: running product or partial remainder; mcand: multiplicand or divisor;
  // shreg: multiplier being consumed or dividend turning into the quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             mul_q, mul_d;

  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;

  assign remShift = {acc_q, shreg_q[WIDTH-1]};
  assign remDiff  = remShift - {1'b0, mcand_q};
  assign done     = busy_q && (cnt_q == LAST);

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mul_d   = mul_q;
    if (start) begin
      mul_d   = (op == OP_MUL);
      acc_d   = '0;
      mcand_d = (op == OP_MUL) ? a : b;
      shreg_d = (op == OP_MUL) ? b : a;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (mul_q) begin
        if (shreg_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d = mcand_q << 1;
        shreg_d = shreg_q >> 1;
      end else if (!remDiff[WIDTH]) begin
        // No borrow: the divisor fits, so keep the difference and emit a 1.
        acc_d   = remDiff[WIDTH-1:0];
        shreg_d = {shreg_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d   = remShift[WIDTH-1:0];
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (done) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      mcand_q <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      mul_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      mul_q   <= mul_d;
    end
  end

  assign product_lo = acc_d;
  assign quotient   = shreg_d;
  assign remainder  = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle logic/arith ops plus iterative unsigned MUL/DIVU/REMU.
// Result, zero and illegal are registered and held until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] alu_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              illegal
);

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic [3:0]       op_q;

  logic [3:0]       opCode;
  logic             opLegal;
  logic             divByZero;
  logic             goIter;
  logic             iterDone;
  logic [WIDTH-1:0] singleResult;
  logic [WIDTH-1:0] iterResult;
  logic [WIDTH-1:0] prodLo;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  // Op codes are four bits wide; any set bit above them makes the code illegal.
  assign opCode  = alu_ctrl[3:0];
  assign opLegal = (alu_ctrl == CTRL_W'(OP_AND))  || (alu_ctrl == CTRL_W'(OP_OR))   ||
                   (alu_ctrl == CTRL_W'(OP_ADD))  || (alu_ctrl == CTRL_W'(OP_SUB))  ||
                   (alu_ctrl == CTRL_W'(OP_MUL))  || (alu_ctrl == CTRL_W'(OP_DIVU)) ||
                   (alu_ctrl == CTRL_W'(OP_REMU));

  assign divByZero = is_divide(opCode) && (b == '0);
  assign goIter    = in_ready_q && in_valid && opLegal && is_iterative(opCode) && !divByZero;

  always_comb begin
    singleResult = '0;
    if (opLegal) begin
      case (opCode)
        OP_AND:  singleResult = a & b;
        OP_OR:   singleResult = a | b;
        OP_ADD:  singleResult = a + b;
        OP_SUB:  singleResult = a - b;
        OP_DIVU: singleResult = '1;
        OP_REMU: singleResult = a;
        default: singleResult = '0;
      endcase
    end
  end

  assign iterResult = (op_q == OP_MUL)  ? prodLo :
                      (op_q == OP_DIVU) ? quot   : rem;

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (goIter),
    .op        (opCode),
    .a         (a),
    .b         (b),
    .done      (iterDone),
    .product_lo(prodLo),
    .quotient  (quot),
    .remainder (rem)
  );

  // zero is always taken from the value being written into result on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
      op_q        <= OP_AND;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q       <= opCode;
            in_ready_q <= 1'b0;
            if (goIter) begin
              state_q <= ST_ITER;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              result_q    <= singleResult;
              zero_q      <= (singleResult == '0);
              illegal_q   <= !opLegal;
            end
          end
        end
        ST_ITER: begin
          if (iterDone) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            result_q    <= iterResult;
            zero_q      <= (iterResult == '0);
            illegal_q   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
